// File: rtl/dmx512_rx.sv
// DMX512 receiver: break/MAB detection, 8N2 slot deserialiser, 512-slot buffer with registered read.
// Slots are written at their second stop-bit sample; read_data follows read_addr by one cycle; no backpressure.
module dmx512_rx #(
  parameter int BIT_TIME  = 200,
  parameter int BREAK_MIN = 4400,
  parameter int MAB_MIN   = 400
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       dmx_in,
  input  logic [9:0] read_addr,
  output logic [7:0] read_data,
  output logic [7:0] start_code,
  output logic [9:0] slot_count,
  output logic       packet_done,
  output logic       frame_err
);

  localparam logic [15:0] HALF_LAST = 16'(BIT_TIME / 2 - 1);
  localparam logic [15:0] BIT_LAST  = 16'(BIT_TIME - 1);
  localparam logic [12:0] BRK_CNT   = 13'(BREAK_MIN);
  localparam logic [12:0] MAB_CNT   = 13'(MAB_MIN);

  typedef enum logic [2:0] {
    S_HUNT, S_BREAK, S_MAB, S_START, S_DATA, S_STOP, S_MARK
  } state_t;

  state_t      state, state_nxt;
  logic [1:0]  sync;
  logic        rx;
  logic [12:0] low_cnt;
  logic [12:0] high_tmr, high_tmr_nxt;
  logic [15:0] bit_tmr, bit_tmr_nxt;
  logic [2:0]  bit_cnt, bit_cnt_nxt;
  logic [7:0]  shift, shift_nxt;
  logic [9:0]  slot_idx, slot_idx_nxt;
  logic [7:0]  pend_sc, pend_sc_nxt;
  logic        brk_pend, brk_pend_nxt;
  logic [7:0]  start_code_nxt;
  logic [9:0]  slot_count_nxt;
  logic        done_nxt, err_nxt;
  logic        wr_en;
  logic [8:0]  wr_addr;
  logic [7:0]  wr_data;

  always_ff @(posedge clk) begin
    if (rst) sync <= 2'b11;
    else     sync <= {sync[0], dmx_in};
  end
  assign rx = sync[1];

  always_ff @(posedge clk) begin
    if (rst || rx)               low_cnt <= '0;
    else if (low_cnt != 13'h1fff) low_cnt <= low_cnt + 13'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_HUNT;
      high_tmr    <= '0;
      bit_tmr     <= '0;
      bit_cnt     <= '0;
      shift       <= '0;
      slot_idx    <= '0;
      pend_sc     <= '0;
      brk_pend    <= 1'b0;
      start_code  <= '0;
      slot_count  <= '0;
      packet_done <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      state       <= state_nxt;
      high_tmr    <= high_tmr_nxt;
      bit_tmr     <= bit_tmr_nxt;
      bit_cnt     <= bit_cnt_nxt;
      shift       <= shift_nxt;
      slot_idx    <= slot_idx_nxt;
      pend_sc     <= pend_sc_nxt;
      brk_pend    <= brk_pend_nxt;
      start_code  <= start_code_nxt;
      slot_count  <= slot_count_nxt;
      packet_done <= done_nxt;
      frame_err   <= err_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    high_tmr_nxt   = high_tmr;
    bit_tmr_nxt    = bit_tmr;
    bit_cnt_nxt    = bit_cnt;
    shift_nxt      = shift;
    slot_idx_nxt   = slot_idx;
    pend_sc_nxt    = pend_sc;
    brk_pend_nxt   = brk_pend;
    start_code_nxt = start_code;
    slot_count_nxt = slot_count;
    done_nxt       = 1'b0;
    err_nxt        = 1'b0;
    wr_en          = 1'b0;
    wr_addr        = slot_idx[8:0] - 9'd1;
    wr_data        = shift;

    if (low_cnt == BRK_CNT) begin
      state_nxt    = S_BREAK;
      brk_pend_nxt = 1'b0;
      slot_idx_nxt = '0;
      if ((state inside {S_START, S_DATA, S_STOP, S_MARK}) && slot_idx != 10'd0) begin
        done_nxt       = 1'b1;
        start_code_nxt = pend_sc;
        slot_count_nxt = slot_idx - 10'd1;
      end
    end else begin
      case (state)
        S_HUNT: ;
        S_BREAK: begin
          if (rx) begin
            state_nxt    = S_MAB;
            high_tmr_nxt = '0;
          end
        end
        S_MAB: begin
          if (!rx) begin
            if (high_tmr >= MAB_CNT) begin
              state_nxt    = S_START;
              slot_idx_nxt = '0;
              bit_tmr_nxt  = '0;
            end else begin
              state_nxt = S_HUNT;
            end
          end else if (high_tmr != 13'h1fff) begin
            high_tmr_nxt = high_tmr + 13'd1;
          end
        end
        S_START: begin
          if (bit_tmr == HALF_LAST) begin
            bit_tmr_nxt = '0;
            if (!rx) begin
              state_nxt   = S_DATA;
              bit_cnt_nxt = '0;
            end else begin
              state_nxt = (slot_idx == 10'd0) ? S_MAB : S_MARK;
            end
          end else begin
            bit_tmr_nxt = bit_tmr + 16'd1;
          end
        end
        S_DATA: begin
          if (bit_tmr == BIT_LAST) begin
            bit_tmr_nxt = '0;
            shift_nxt   = {shift[6:0], rx};
            bit_cnt_nxt = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state_nxt = S_STOP;
          end else begin
            bit_tmr_nxt = bit_tmr + 16'd1;
          end
        end
        S_STOP: begin
          // An all-zero slot with a low stop bit may be the front of a break: defer the verdict.
          if (brk_pend) begin
            if (rx) begin
              err_nxt      = 1'b1;
              brk_pend_nxt = 1'b0;
              state_nxt    = S_HUNT;
              slot_idx_nxt = '0;
            end
          end else if (bit_tmr == BIT_LAST) begin
            bit_tmr_nxt = '0;
            if (!rx) begin
              if (bit_cnt == 3'd0 && shift == 8'h00) begin
                brk_pend_nxt = 1'b1;
              end else begin
                err_nxt      = 1'b1;
                state_nxt    = S_HUNT;
                slot_idx_nxt = '0;
              end
            end else if (bit_cnt == 3'd0) begin
              bit_cnt_nxt = 3'd1;
            end else begin
              bit_cnt_nxt = '0;
              if (slot_idx == 10'd0)  pend_sc_nxt = shift;
              else if (pend_sc == 8'h00) wr_en = 1'b1;
              if (slot_idx == 10'd512) begin
                done_nxt       = 1'b1;
                start_code_nxt = pend_sc;
                slot_count_nxt = slot_idx;
                state_nxt      = S_HUNT;
                slot_idx_nxt   = '0;
              end else begin
                slot_idx_nxt = slot_idx + 10'd1;
                state_nxt    = S_MARK;
              end
            end
          end else begin
            bit_tmr_nxt = bit_tmr + 16'd1;
          end
        end
        S_MARK: begin
          if (!rx) begin
            state_nxt   = S_START;
            bit_tmr_nxt = '0;
          end
        end
        default: state_nxt = S_HUNT;
      endcase
    end
  end

  // Slot buffer: buffer[n] lives at mem[n-1]; a sweep after reset zeroes it.
  logic [7:0] mem [0:511];
  logic [8:0] clr_idx;
  logic       clearing;
  logic       mem_we;
  logic [8:0] mem_wa;
  logic [7:0] mem_wd;
  logic       rd_ok;
  logic [8:0] rd_idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      clr_idx  <= '0;
      clearing <= 1'b1;
    end else if (clearing) begin
      clr_idx <= clr_idx + 9'd1;
      if (clr_idx == 9'd511) clearing <= 1'b0;
    end
  end

  assign mem_we = clearing || wr_en;
  assign mem_wa = clearing ? clr_idx : wr_addr;
  assign mem_wd = clearing ? 8'h00 : wr_data;

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_wa] <= mem_wd;
  end

  assign rd_ok  = (read_addr != 10'd0) && (read_addr <= 10'd512);
  assign rd_idx = read_addr[8:0] - 9'd1;

  always_ff @(posedge clk) begin
    if (rst || clearing || !rd_ok) read_data <= 8'h00;
    else                           read_data <= mem[rd_idx];
  end

endmodule

// File: tb/tb_dmx512_rx.sv
// Directed bench for dmx512_rx with shortened bit timing; packet results are scoreboarded.
module tb_dmx512_rx;
  localparam int BT  = 4;
  localparam int BRK = 88;
  localparam int MAB = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       dmx_in = 1'b1;
  logic [9:0] read_addr = '0;
  logic [7:0] read_data, start_code;
  logic [9:0] slot_count;
  logic       packet_done, frame_err;

  typedef struct packed { logic [7:0] sc; logic [9:0] cnt; } exp_t;
  exp_t exp_q[$];

  int total = 0, bad = 0, done_cnt = 0, err_cnt = 0, cyc = 0, done_cyc = 0;

  dmx512_rx #(.BIT_TIME(BT), .BREAK_MIN(BRK), .MAB_MIN(MAB)) dut (
    .clk(clk), .rst(rst), .dmx_in(dmx_in), .read_addr(read_addr),
    .read_data(read_data), .start_code(start_code), .slot_count(slot_count),
    .packet_done(packet_done), .frame_err(frame_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic push_exp(input logic [7:0] sc, input logic [9:0] cnt);
    exp_t e;
    e.sc  = sc;
    e.cnt = cnt;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    if (frame_err === 1'b1) err_cnt++;
    if (packet_done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
      total++;
      assert (exp_q.size() != 0) else begin
        bad++;
        $error("FAIL unexpected_packet_done observed=1 expected=0");
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("done_start_code", start_code, e.sc);
        chk("done_slot_count", slot_count, e.cnt);
      end
    end
  end

  task automatic line(input logic v, input int n);
    dmx_in = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_slot(input logic [7:0] d, input logic stop1);
    line(1'b0, BT);
    for (int i = 7; i >= 0; i--) line(d[i], BT);
    line(stop1, BT);
    line(1'b1, BT);
  endtask

  task automatic read_chk(input logic [9:0] a, input logic [7:0] expv, input string tag);
    read_addr = a;
    @(negedge clk);
    chk(tag, read_data, expv);
  endtask

  task automatic wait_done(input int target, input string tag);
    int n = 0;
    while (done_cnt < target && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk(tag, done_cnt, target);
  endtask

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int brk_cyc, d;
    logic [7:0] v;

    repeat (3) @(negedge clk);
    chk("rst_read_data", read_data, 8'h00);
    chk("rst_start_code", start_code, 8'h00);
    chk("rst_slot_count", slot_count, 10'd0);
    chk("rst_packet_done", packet_done, 1'b0);
    chk("rst_frame_err", frame_err, 1'b0);
    rst = 1'b0;
    read_chk(10'd5, 8'h00, "read_in_clear");
    repeat (520) @(negedge clk);

    // Full 512-slot packet, start code 00, slot n = n[7:0]
    line(1'b0, 100);
    line(1'b1, 12);
    send_slot(8'h00, 1'b1);
    for (int n = 1; n <= 512; n++) begin
      if (n == 512) push_exp(8'h00, 10'd512);
      send_slot(n[7:0], 1'b1);
    end
    wait_done(1, "full_done");
    read_chk(10'd5,   8'h05, "full_rd5");
    read_chk(10'd255, 8'hFF, "full_rd255");
    read_chk(10'd500, 8'hF4, "full_rd500");
    read_chk(10'd512, 8'h00, "full_rd512");
    read_chk(10'd511, 8'hFF, "full_rd511");
    read_chk(10'd0,   8'h00, "rd_addr0");
    read_chk(10'd513, 8'h00, "rd_addr513");

    // Short packet closed by the next break
    line(1'b0, 100);
    line(1'b1, 12);
    send_slot(8'h00, 1'b1);
    send_slot(8'hAA, 1'b1);
    send_slot(8'h55, 1'b1);
    send_slot(8'h0F, 1'b1);
    push_exp(8'h00, 10'd3);
    brk_cyc = cyc;
    line(1'b0, 100);
    wait_done(2, "short_done");
    d = done_cyc - brk_cyc;
    chk("short_break_latency_in_window", (d >= BRK && d <= BRK + 5), 1);
    read_chk(10'd1, 8'hAA, "short_rd1");
    read_chk(10'd2, 8'h55, "short_rd2");
    read_chk(10'd3, 8'h0F, "short_rd3");
    read_chk(10'd4, 8'h04, "short_rd4_kept");

    // Non-zero start code leaves the buffer alone
    line(1'b1, 12);
    send_slot(8'hCC, 1'b1);
    send_slot(8'h11, 1'b1);
    send_slot(8'h22, 1'b1);
    push_exp(8'hCC, 10'd2);
    line(1'b0, 100);
    wait_done(3, "cc_done");
    chk("cc_start_code", start_code, 8'hCC);
    read_chk(10'd1, 8'hAA, "cc_rd1");
    read_chk(10'd2, 8'h55, "cc_rd2");

    // Framing error on slot 2, then a break that must not complete anything
    line(1'b1, 12);
    send_slot(8'h00, 1'b1);
    send_slot(8'h31, 1'b1);
    send_slot(8'h32, 1'b0);
    send_slot(8'h33, 1'b1);
    chk("ferr_count", err_cnt, 1);
    line(1'b0, 100);
    chk("ferr_no_done", done_cnt, 3);
    read_chk(10'd2, 8'h55, "ferr_slot2_discarded");
    line(1'b1, 12);
    send_slot(8'h00, 1'b1);
    send_slot(8'h41, 1'b1);
    send_slot(8'h42, 1'b1);
    push_exp(8'h00, 10'd2);
    line(1'b0, 100);
    wait_done(4, "after_ferr_done");
    read_chk(10'd1, 8'h41, "after_ferr_rd1");
    read_chk(10'd2, 8'h42, "after_ferr_rd2");
    read_chk(10'd3, 8'h0F, "after_ferr_rd3");

    // Short MAB drops to HUNT; an 80 us low is not a break
    line(1'b1, 4);
    send_slot(8'h55, 1'b1);
    line(1'b0, 80);
    line(1'b1, 12);
    send_slot(8'h00, 1'b1);
    send_slot(8'h77, 1'b1);
    line(1'b1, 20);
    line(1'b0, 100);
    chk("short_low_no_done", done_cnt, 4);
    chk("short_low_no_err", err_cnt, 1);
    read_chk(10'd1, 8'h41, "short_low_rd1");

    // Reset in the middle of slot 10
    line(1'b1, 12);
    send_slot(8'h00, 1'b1);
    for (int n = 1; n <= 9; n++) begin
      v = 8'h90 + n[7:0];
      send_slot(v, 1'b1);
    end
    read_chk(10'd1, 8'h91, "pre_rst_rd1");
    line(1'b0, BT);
    line(1'b1, BT);
    line(1'b0, BT);
    rst = 1'b1;
    dmx_in = 1'b1;
    repeat (3) @(negedge clk);
    chk("midrst_read_data", read_data, 8'h00);
    chk("midrst_start_code", start_code, 8'h00);
    chk("midrst_slot_count", slot_count, 10'd0);
    chk("midrst_packet_done", packet_done, 1'b0);
    chk("midrst_frame_err", frame_err, 1'b0);
    rst = 1'b0;
    read_addr = 10'd500;
    repeat (10) @(negedge clk);
    chk("midrst_read_during_clear", read_data, 8'h00);
    chk("midrst_no_done", done_cnt, 4);
    chk("midrst_no_err", err_cnt, 1);
    repeat (520) @(negedge clk);
    read_chk(10'd500, 8'h00, "cleared_rd500");

    // Second full packet after reset
    line(1'b0, 100);
    line(1'b1, 12);
    send_slot(8'h00, 1'b1);
    for (int n = 1; n <= 512; n++) begin
      v = n[7:0] ^ 8'h5A;
      if (n == 512) push_exp(8'h00, 10'd512);
      send_slot(v, 1'b1);
    end
    wait_done(5, "full2_done");
    read_chk(10'd1,   8'h5B, "full2_rd1");
    read_chk(10'd10,  8'h50, "full2_rd10");
    read_chk(10'd300, 8'h76, "full2_rd300");
    read_chk(10'd512, 8'h5A, "full2_rd512");
    chk("full2_slot_count", slot_count, 10'd512);
    chk("final_err_count", err_cnt, 1);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dmx512_rx.md
DMX512_RX -- requirements
Module: dmx512_rx

Interface
REQ-001 SHALL have port: clk  input  1  system clock, 50 MHz, all logic on rising edge.
REQ-002 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL have port: dmx_in  input  1  asynchronous DMX line, idle high.
REQ-004 SHALL have port: read_addr  input  10  slot to read, 1..512.
REQ-005 SHALL have port: read_data  output  8  registered slot value.
REQ-006 SHALL have port: start_code  output  8  start code of the last completed packet.
REQ-007 SHALL have port: slot_count  output  10  data slots (excluding start code) in the last completed packet.
REQ-008 SHALL have port: packet_done  output  1  one-cycle pulse when a packet completes.
REQ-009 SHALL have port: frame_err  output  1  one-cycle pulse on a slot framing error.
REQ-010 SHALL have parameters: BIT_TIME, default 200, cycles per bit (4 us).
REQ-011 SHALL have parameters: BREAK_MIN, default 4400, minimum low cycles for a break (88 us).
REQ-012 SHALL have parameters: MAB_MIN, default 400, minimum high cycles for mark-after-break (8 us).

Function
REQ-013 SHALL pass dmx_in through a 2-flop synchronizer; all timing SHALL refer to the synchronized signal (rx).
REQ-014 SHALL keep a low-run counter: cleared when rx=1, incremented when rx=0, saturating at 8191.
REQ-015 SHALL enter BREAK from any state when the low-run counter reaches BREAK_MIN, aborting any slot in progress.
REQ-016 States: HUNT, BREAK, MAB, START, DATA, STOP, MARK.
REQ-017 HUNT: entered after reset; leaves only via REQ-015.
REQ-018 BREAK: wait for rx=1, then go to MAB with the high timer cleared.
REQ-019 MAB: on rx=0 with high timer >= MAB_MIN, go to START (slot index 0); on rx=0 with high timer < MAB_MIN, go to HUNT without an error pulse.
REQ-020 START: sample rx after BIT_TIME/2 cycles; if 0, go to DATA with bit timer cleared; if 1 (glitch), return to MARK, or to MAB if slot index is 0.
REQ-021 DATA: sample every BIT_TIME cycles from the start-bit midpoint; 8 samples, first sample = bit 7 (MSB-first), then go to STOP.
REQ-022 STOP: sample 2 stop bits at BIT_TIME spacing; both 1 means slot accepted, otherwise pulse frame_err, discard the slot, and go to HUNT.
REQ-023 Accepted slot 0 SHALL be held as the pending start code; accepted slot n (1..512) SHALL be written to buffer[n] only when the pending start code is 8'h00.
REQ-024 After an accepted slot, go to MARK and increment the slot index; MARK goes to START on rx=0.
REQ-025 Packet completes when slot index 512 is accepted (go to HUNT) or when REQ-015 fires with slot index >= 1.
REQ-026 On completion: packet_done pulses for 1 cycle, start_code is set to the pending code, and slot_count is set to (slots accepted - 1).
REQ-027 A break after a framing error or during MAB SHALL NOT pulse packet_done.
REQ-028 Buffer: 512 x 8; read_data = buffer[read_addr] one cycle after read_addr; read_addr of 0 or > 512 returns 8'h00.
REQ-029 If a write and a read hit the same address in the same cycle, read_data SHALL return the old value.
REQ-030 Slots beyond slot_count keep their values from earlier packets.

Reset
REQ-031 On rst: state HUNT; synchronizer flops 1; counters 0; start_code 0; slot_count 0; read_data 0; packet_done 0; frame_err 0.
REQ-032 Buffer contents SHALL be cleared to 0 by reset, using a sequential 512-cycle clear; reads during the clear return 0.
REQ-033 rst asserted mid-packet SHALL discard the packet and produce no pulses.

Verification
REQ-034 Full packet: break 100 us, MAB 12 us, start code 00, slot n = n[7:0] for 512 slots -> packet_done once; slot_count=512; read addr 5 -> 05, addr 512 -> 00.
REQ-035 Short packet: 3 slots AA 55 0F, then a new break -> packet_done at break+BREAK_MIN; slot_count=3; slots 1..3 = AA 55 0F.
REQ-036 Non-zero start code CC, slots 11 22 -> start_code=CC; buffer unchanged from the prior packet.
REQ-037 Slot 2 first stop bit held low -> frame_err pulse; no packet_done; next valid packet received normally.
REQ-038 Low pulse of 80 us (below BREAK_MIN) -> no BREAK entered; MAB of 4 us -> HUNT, no pulses.
REQ-039 rst asserted mid-slot 10 -> all outputs 0; next full packet received correctly.
